// File: rtl/axis_stream_rxfifo_pkg.sv
// Shared constants and types for the AXI-Stream RX FIFO: register map, STATUS layout,
// AXI response codes and channel FSM states.
package axis_stream_rxfifo_pkg;

   localparam int unsigned AXIL_DATA_W = 32;
   localparam int unsigned AXIL_ADDR_W = 4;
   localparam int unsigned FIFO_DATA_W = 33;

   localparam logic [3:0] REG_DATA    = 4'h0;
   localparam logic [3:0] REG_STATUS  = 4'h4;
   localparam logic [3:0] REG_CONTROL = 4'h8;
   localparam logic [3:0] REG_PKTCNT  = 4'hC;

   localparam int unsigned ST_EMPTY_BIT = 16;
   localparam int unsigned ST_FULL_BIT  = 17;
   localparam int unsigned ST_LAST_BIT  = 18;
   localparam int unsigned ST_STALL_BIT = 19;

   localparam int unsigned CTRL_FLUSH_BIT     = 0;
   localparam int unsigned CTRL_CLR_STALL_BIT = 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wr_state_e;
   typedef enum logic {R_IDLE, R_DATA} rd_state_e;

endpackage

// File: rtl/axis_stream_rxfifo_if.sv
// Bundles the AXI4-Stream input and the AXI4-Lite (S00_AXI) register port of the RX FIFO.
interface axis_stream_rxfifo_if;
   import axis_stream_rxfifo_pkg::*;

   logic [AXIL_DATA_W-1:0] s_axis_tdata;
   logic                   s_axis_tlast;
   logic                   s_axis_tvalid;
   logic                   s_axis_tready;

   logic [AXIL_ADDR_W-1:0] s00_axi_awaddr;
   logic [2:0]             s00_axi_awprot;
   logic                   s00_axi_awvalid;
   logic                   s00_axi_awready;
   logic [AXIL_DATA_W-1:0] s00_axi_wdata;
   logic [3:0]             s00_axi_wstrb;
   logic                   s00_axi_wvalid;
   logic                   s00_axi_wready;
   logic [1:0]             s00_axi_bresp;
   logic                   s00_axi_bvalid;
   logic                   s00_axi_bready;
   logic [AXIL_ADDR_W-1:0] s00_axi_araddr;
   logic [2:0]             s00_axi_arprot;
   logic                   s00_axi_arvalid;
   logic                   s00_axi_arready;
   logic [AXIL_DATA_W-1:0] s00_axi_rdata;
   logic [1:0]             s00_axi_rresp;
   logic                   s00_axi_rvalid;
   logic                   s00_axi_rready;

   modport slave (
      input  s_axis_tdata, s_axis_tlast, s_axis_tvalid,
      output s_axis_tready,
      input  s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
      output s00_axi_awready,
      input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
      output s00_axi_wready,
      output s00_axi_bresp, s00_axi_bvalid,
      input  s00_axi_bready,
      input  s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
      output s00_axi_arready,
      output s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
      input  s00_axi_rready
   );

   modport master (
      output s_axis_tdata, s_axis_tlast, s_axis_tvalid,
      input  s_axis_tready,
      output s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
      input  s00_axi_awready,
      output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
      input  s00_axi_wready,
      input  s00_axi_bresp, s00_axi_bvalid,
      output s00_axi_bready,
      output s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
      input  s00_axi_arready,
      input  s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
      output s00_axi_rready
   );

endinterface

// File: rtl/axis_stream_rxfifo_sync_fifo.sv
// Synchronous FIFO with push, pop and flush; head entry is visible combinationally.
// Only pointers and level are reset; the storage array is not.
module rxfifo_sync_fifo
   import axis_stream_rxfifo_pkg::*;
#(
   parameter int unsigned DATA_W = FIFO_DATA_W,
   parameter int unsigned ADDR_W = 9
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_din,
   input  logic              i_pop,
   input  logic              i_flush,
   output logic [DATA_W-1:0] o_head,
   output logic [ADDR_W:0]   o_level,
   output logic [ADDR_W:0]   o_level_nxt,
   output logic              o_full,
   output logic              o_empty
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0]   LVL_FULL = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   LVL_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_level;
   logic [ADDR_W:0]   w_level_d;
   logic              w_push;
   logic              w_pop;

   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   always_comb begin
      w_level_d = r_level;
      if (i_flush) begin
         w_level_d = '0;
      end else if (w_push && !w_pop) begin
         w_level_d = r_level + LVL_ONE;
      end else if (!w_push && w_pop) begin
         w_level_d = r_level - LVL_ONE;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         r_level <= w_level_d;
         if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_din;
   end

   assign o_head      = r_mem[r_rd_ptr];
   assign o_level     = r_level;
   assign o_level_nxt = w_level_d;
   assign o_full      = (r_level == LVL_FULL);
   assign o_empty     = (r_level == '0);

endmodule

// File: rtl/axis_stream_rxfifo.sv
// AXI-Stream receive FIFO drained by software through a 4-register AXI4-Lite slave
// (DATA pop, STATUS, CONTROL, PKT_COUNT).
module axis_stream_rxfifo
   import axis_stream_rxfifo_pkg::*;
#(
   parameter int unsigned C_S00_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S00_AXI_ADDR_WIDTH = 4,
   parameter int unsigned FIFO_ADDR_W          = 9
) (
   input  logic                i_aclk,
   input  logic                i_aresetn,
   axis_stream_rxfifo_if.slave io_bus
);
   localparam logic [FIFO_ADDR_W:0] LVL_FULL = {1'b1, {FIFO_ADDR_W{1'b0}}};
   localparam logic [FIFO_ADDR_W:0] CNT_ONE  = {{FIFO_ADDR_W{1'b0}}, 1'b1};

   wr_state_e r_wr_state, w_wr_state_d;
   rd_state_e r_rd_state, w_rd_state_d;

   logic [C_S00_AXI_ADDR_WIDTH-1:0] w_awaddr;
   logic [C_S00_AXI_ADDR_WIDTH-1:0] w_araddr;
   logic [C_S00_AXI_DATA_WIDTH-1:0] w_status;
   logic [C_S00_AXI_DATA_WIDTH-1:0] w_rdata_d;
   logic [C_S00_AXI_DATA_WIDTH-1:0] r_rdata;
   logic [1:0]                      w_rresp_d;
   logic [1:0]                      r_rresp;
   logic                            w_aw_acc;
   logic                            w_ar_acc;
   logic                            w_ctrl_wr;
   logic                            w_flush;
   logic                            w_clr_stall;
   logic                            w_push;
   logic                            w_pop;
   logic                            w_push_last;
   logic                            w_pop_last;
   logic                            r_tready;
   logic                            r_stall;
   logic [FIFO_ADDR_W:0]            r_pkt_cnt;
   logic [FIFO_ADDR_W:0]            w_level;
   logic [FIFO_ADDR_W:0]            w_level_nxt;
   logic                            w_full;
   logic                            w_empty;
   logic [FIFO_DATA_W-1:0]          w_head;
   logic                            w_unused;

   assign w_awaddr = io_bus.s00_axi_awaddr;
   assign w_araddr = io_bus.s00_axi_araddr;

   // Write channel
   always_comb begin
      w_wr_state_d = r_wr_state;
      w_aw_acc     = 1'b0;
      unique case (r_wr_state)
         W_IDLE: begin
            if (io_bus.s00_axi_awvalid && io_bus.s00_axi_wvalid) begin
               w_aw_acc     = 1'b1;
               w_wr_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (io_bus.s00_axi_bready) w_wr_state_d = W_IDLE;
         end
         default: w_wr_state_d = W_IDLE;
      endcase
   end

   // Read channel
   always_comb begin
      w_rd_state_d = r_rd_state;
      w_ar_acc     = 1'b0;
      unique case (r_rd_state)
         R_IDLE: begin
            if (io_bus.s00_axi_arvalid) begin
               w_ar_acc     = 1'b1;
               w_rd_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (io_bus.s00_axi_rready) w_rd_state_d = R_IDLE;
         end
         default: w_rd_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_wr_state <= W_IDLE;
         r_rd_state <= R_IDLE;
      end else begin
         r_wr_state <= w_wr_state_d;
         r_rd_state <= w_rd_state_d;
      end
   end

   assign w_ctrl_wr   = w_aw_acc && (w_awaddr[3:2] == REG_CONTROL[3:2]);
   assign w_flush     = w_ctrl_wr && io_bus.s00_axi_wdata[CTRL_FLUSH_BIT];
   assign w_clr_stall = w_ctrl_wr && io_bus.s00_axi_wdata[CTRL_CLR_STALL_BIT];
   assign w_push      = io_bus.s_axis_tvalid && r_tready;
   assign w_pop       = w_ar_acc && (w_araddr[3:2] == REG_DATA[3:2]) && !w_empty;
   assign w_push_last = w_push && io_bus.s_axis_tlast;
   assign w_pop_last  = w_pop && w_head[32];

   rxfifo_sync_fifo #(
      .DATA_W (FIFO_DATA_W),
      .ADDR_W (FIFO_ADDR_W)
   ) u_fifo (
      .i_clk       (i_aclk),
      .i_rst_n     (i_aresetn),
      .i_push      (w_push),
      .i_din       ({io_bus.s_axis_tlast, io_bus.s_axis_tdata}),
      .i_pop       (w_pop),
      .i_flush     (w_flush),
      .o_head      (w_head),
      .o_level     (w_level),
      .o_level_nxt (w_level_nxt),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   always_comb begin
      w_status                  = '0;
      w_status[FIFO_ADDR_W:0]   = w_level;
      w_status[ST_EMPTY_BIT]    = w_empty;
      w_status[ST_FULL_BIT]     = w_full;
      w_status[ST_LAST_BIT]     = !w_empty && w_head[32];
      w_status[ST_STALL_BIT]    = r_stall;
   end

   always_comb begin
      w_rdata_d = '0;
      w_rresp_d = RESP_OKAY;
      unique case (w_araddr[3:2])
         REG_DATA[3:2]: begin
            if (w_empty) w_rresp_d = RESP_SLVERR;
            else         w_rdata_d = w_head[31:0];
         end
         REG_STATUS[3:2]: w_rdata_d = w_status;
         REG_PKTCNT[3:2]: w_rdata_d[FIFO_ADDR_W:0] = r_pkt_cnt;
         default: ;
      endcase
   end

   // TREADY is looked ahead from next level so a full FIFO never sees an accepted beat
   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
         r_tready  <= 1'b0;
         r_stall   <= 1'b0;
         r_pkt_cnt <= '0;
      end else begin
         if (w_ar_acc) begin
            r_rdata <= w_rdata_d;
            r_rresp <= w_rresp_d;
         end
         r_tready <= (w_level_nxt != LVL_FULL);
         if (io_bus.s_axis_tvalid && !r_tready) r_stall <= 1'b1;
         else if (w_clr_stall)                  r_stall <= 1'b0;
         if (w_flush)                          r_pkt_cnt <= '0;
         else if (w_push_last && !w_pop_last)  r_pkt_cnt <= r_pkt_cnt + CNT_ONE;
         else if (!w_push_last && w_pop_last)  r_pkt_cnt <= r_pkt_cnt - CNT_ONE;
      end
   end

   assign io_bus.s_axis_tready   = r_tready;
   assign io_bus.s00_axi_awready = w_aw_acc;
   assign io_bus.s00_axi_wready  = w_aw_acc;
   assign io_bus.s00_axi_bvalid  = (r_wr_state == W_RESP);
   assign io_bus.s00_axi_bresp   = RESP_OKAY;
   assign io_bus.s00_axi_arready = w_ar_acc;
   assign io_bus.s00_axi_rvalid  = (r_rd_state == R_DATA);
   assign io_bus.s00_axi_rdata   = r_rdata;
   assign io_bus.s00_axi_rresp   = r_rresp;

   assign w_unused = ^{io_bus.s00_axi_awprot, io_bus.s00_axi_arprot, io_bus.s00_axi_wstrb,
                       io_bus.s00_axi_wdata[31:2], w_awaddr[1:0], w_araddr[1:0]};

endmodule

// File: tb/tb_axis_stream_rxfifo.sv
// Randomised bench for axis_stream_rxfifo against a queue-based model of the FIFO contents.
module tb_axis_stream_rxfifo;
   import axis_stream_rxfifo_pkg::*;

   localparam int DEPTH = 512;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [32:0] model_q [$];
   logic        model_stall = 1'b0;

   axis_stream_rxfifo_if u_if ();

   axis_stream_rxfifo #(
      .C_S00_AXI_DATA_WIDTH (32),
      .C_S00_AXI_ADDR_WIDTH (4),
      .FIFO_ADDR_W          (9)
   ) u_dut (
      .i_aclk    (clk),
      .i_aresetn (rst_n),
      .io_bus    (u_if)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] model_status();
      logic [31:0] s;
      s        = '0;
      s[15:0]  = 16'(model_q.size());
      s[16]    = (model_q.size() == 0);
      s[17]    = (model_q.size() == DEPTH);
      s[18]    = (model_q.size() != 0) ? model_q[0][32] : 1'b0;
      s[19]    = model_stall;
      return s;
   endfunction

   function automatic logic [31:0] model_pkts();
      int c;
      c = 0;
      foreach (model_q[i]) if (model_q[i][32]) c++;
      return 32'(c);
   endfunction

   task automatic bus_idle();
      u_if.s_axis_tdata    = '0;
      u_if.s_axis_tlast    = 1'b0;
      u_if.s_axis_tvalid   = 1'b0;
      u_if.s00_axi_awaddr  = '0;
      u_if.s00_axi_awprot  = '0;
      u_if.s00_axi_awvalid = 1'b0;
      u_if.s00_axi_wdata   = '0;
      u_if.s00_axi_wstrb   = 4'hF;
      u_if.s00_axi_wvalid  = 1'b0;
      u_if.s00_axi_bready  = 1'b0;
      u_if.s00_axi_araddr  = '0;
      u_if.s00_axi_arprot  = '0;
      u_if.s00_axi_arvalid = 1'b0;
      u_if.s00_axi_rready  = 1'b0;
   endtask

   // Holds TVALID until the beat is accepted; any refused cycle sets the model stall flag.
   task automatic send_beat(input logic [31:0] data, input logic last);
      int n;
      @(negedge clk);
      u_if.s_axis_tvalid = 1'b1;
      u_if.s_axis_tdata  = data;
      u_if.s_axis_tlast  = last;
      #1;
      n = 0;
      while (!u_if.s_axis_tready && n < 4000) begin
         model_stall = 1'b1;
         @(negedge clk);
         #1;
         n++;
      end
      if (!u_if.s_axis_tready) begin
         n_cmp++;
         n_err++;
         $display("FAIL stream_timeout: tready=0 required 1");
      end else begin
         model_q.push_back({last, data});
      end
   endtask

   task automatic stream_stop();
      @(negedge clk);
      u_if.s_axis_tvalid = 1'b0;
      u_if.s_axis_tlast  = 1'b0;
   endtask

   task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      int n;
      data = '0;
      resp = 2'b11;
      @(negedge clk);
      u_if.s00_axi_araddr  = addr;
      u_if.s00_axi_arvalid = 1'b1;
      #1;
      n = 0;
      while (!u_if.s00_axi_arready && n < 1000) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!u_if.s00_axi_arready) begin
         n_cmp++;
         n_err++;
         $display("FAIL arready_timeout: arready=0 required 1");
         u_if.s00_axi_arvalid = 1'b0;
         return;
      end
      @(negedge clk);
      u_if.s00_axi_arvalid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      u_if.s00_axi_rready = 1'b1;
      #1;
      n = 0;
      while (!u_if.s00_axi_rvalid && n < 1000) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!u_if.s00_axi_rvalid) begin
         n_cmp++;
         n_err++;
         $display("FAIL rvalid_timeout: rvalid=0 required 1");
      end else begin
         data = u_if.s00_axi_rdata;
         resp = u_if.s00_axi_rresp;
      end
      @(negedge clk);
      u_if.s00_axi_rready = 1'b0;
   endtask

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                            output logic [1:0] resp);
      int n;
      resp = 2'b11;
      @(negedge clk);
      u_if.s00_axi_awaddr  = addr;
      u_if.s00_axi_wdata   = data;
      u_if.s00_axi_awvalid = 1'b1;
      u_if.s00_axi_wvalid  = 1'b1;
      #1;
      n = 0;
      while (!(u_if.s00_axi_awready && u_if.s00_axi_wready) && n < 1000) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!(u_if.s00_axi_awready && u_if.s00_axi_wready)) begin
         n_cmp++;
         n_err++;
         $display("FAIL awready_timeout: awready/wready=0 required 1");
         u_if.s00_axi_awvalid = 1'b0;
         u_if.s00_axi_wvalid  = 1'b0;
         return;
      end
      @(negedge clk);
      u_if.s00_axi_awvalid = 1'b0;
      u_if.s00_axi_wvalid  = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      u_if.s00_axi_bready = 1'b1;
      #1;
      n = 0;
      while (!u_if.s00_axi_bvalid && n < 1000) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!u_if.s00_axi_bvalid) begin
         n_cmp++;
         n_err++;
         $display("FAIL bvalid_timeout: bvalid=0 required 1");
      end else begin
         resp = u_if.s00_axi_bresp;
      end
      @(negedge clk);
      u_if.s00_axi_bready = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic [1:0]  r;
      bus_idle();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({u_if.s_axis_tready, u_if.s00_axi_awready, u_if.s00_axi_wready, u_if.s00_axi_bvalid,
           u_if.s00_axi_arready, u_if.s00_axi_rvalid} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_handshake: ready/valid=%b required 000000",
                  {u_if.s_axis_tready, u_if.s00_axi_awready, u_if.s00_axi_wready,
                   u_if.s00_axi_bvalid, u_if.s00_axi_arready, u_if.s00_axi_rvalid});
      end
      n_cmp++;
      if (u_if.s00_axi_rdata !== 32'h0 || u_if.s00_axi_rresp !== 2'b00 ||
          u_if.s00_axi_bresp !== 2'b00) begin
         n_err++;
         $display("FAIL reset_data: rdata=%h rresp=%b bresp=%b required 0/00/00",
                  u_if.s00_axi_rdata, u_if.s00_axi_rresp, u_if.s00_axi_bresp);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      axi_read(REG_STATUS, d, r);
      n_cmp++;
      if (d !== 32'h0001_0000 || r !== RESP_OKAY) begin
         n_err++;
         $display("FAIL reset_status: got %h/%b required 00010000/00", d, r);
      end
      axi_read(REG_DATA, d, r);
      n_cmp++;
      if (d !== 32'h0 || r !== RESP_SLVERR) begin
         n_err++;
         $display("FAIL reset_empty_pop: got %h/%b required 00000000/10", d, r);
      end
      axi_read(REG_PKTCNT, d, r);
      n_cmp++;
      if (d !== 32'h0) begin
         n_err++;
         $display("FAIL reset_pktcnt: got %h required 0", d);
      end
   endtask

   task automatic test_packet();
      logic [31:0] d;
      logic [1:0]  r;
      logic [32:0] e;
      for (int i = 1; i <= 4; i++) send_beat(32'(i), (i == 4));
      stream_stop();
      axi_read(REG_PKTCNT, d, r);
      n_cmp++;
      if (d !== 32'h1 || d !== model_pkts()) begin
         n_err++;
         $display("FAIL packet_pktcnt: got %h required 1", d);
      end
      axi_read(REG_STATUS, d, r);
      n_cmp++;
      if (d !== 32'h0004_0000 + 32'h4 - 32'h0004_0000 + 32'h0 || d !== model_status()) begin
         n_err++;
         $display("FAIL packet_status: got %h required 00000004", d);
      end
      for (int i = 1; i <= 4; i++) begin
         axi_read(REG_DATA, d, r);
         e = model_q.pop_front();
         n_cmp++;
         if (d !== 32'(i) || d !== e[31:0] || r !== RESP_OKAY) begin
            n_err++;
            $display("FAIL packet_pop%0d: got %h/%b required %h/00", i, d, r, i);
         end
      end
      axi_read(REG_PKTCNT, d, r);
      n_cmp++;
      if (d !== 32'h0) begin
         n_err++;
         $display("FAIL packet_pktcnt_end: got %h required 0", d);
      end
      axi_read(REG_STATUS, d, r);
      n_cmp++;
      if (d !== 32'h0001_0000) begin
         n_err++;
         $display("FAIL packet_status_end: got %h required 00010000", d);
      end
   endtask

   task automatic test_fill_stall();
      logic [31:0] d;
      logic [1:0]  r;
      logic [32:0] e;
      int          bad;
      for (int i = 0; i < DEPTH; i++) send_beat($urandom, ($urandom_range(0, 3) == 0));
      @(negedge clk);
      u_if.s_axis_tvalid = 1'b1;
      u_if.s_axis_tdata  = $urandom;
      #1;
      n_cmp++;
      if (u_if.s_axis_tready !== 1'b0) begin
         n_err++;
         $display("FAIL fill_tready_drop: tready=%b required 0", u_if.s_axis_tready);
      end
      model_stall = 1'b1;
      repeat (2) @(negedge clk);
      stream_stop();
      axi_read(REG_STATUS, d, r);
      n_cmp++;
      if (d !== model_status() || d[15:0] !== 16'd512 || d[17] !== 1'b1 || d[19] !== 1'b1) begin
         n_err++;
         $display("FAIL fill_status: got %h required %h", d, model_status());
      end
      axi_read(REG_PKTCNT, d, r);
      n_cmp++;
      if (d !== model_pkts()) begin
         n_err++;
         $display("FAIL fill_pktcnt: got %h required %h", d, model_pkts());
      end
      axi_write(REG_CONTROL, 32'h2, r);
      model_stall = 1'b0;
      n_cmp++;
      if (r !== RESP_OKAY) begin
         n_err++;
         $display("FAIL clr_stall_bresp: got %b required 00", r);
      end
      axi_read(REG_STATUS, d, r);
      n_cmp++;
      if (d !== model_status() || d[19] !== 1'b0) begin
         n_err++;
         $display("FAIL clr_stall_status: got %h required %h", d, model_status());
      end
      bad = 0;
      for (int i = 0; i < DEPTH; i++) begin
         axi_read(REG_DATA, d, r);
         e = model_q.pop_front();
         n_cmp++;
         if (d !== e[31:0] || r !== RESP_OKAY) begin
            n_err++;
            if (bad < 5) $display("FAIL drain_pop%0d: got %h/%b required %h/00", i, d, r, e[31:0]);
            bad++;
         end
      end
      axi_read(REG_STATUS, d, r);
      n_cmp++;
      if (d !== 32'h0001_0000) begin
         n_err++;
         $display("FAIL drain_status: got %h required 00010000", d);
      end
   endtask

   task automatic test_flush();
      logic [31:0] d;
      logic [1:0]  r;
      int          n;
      for (int i = 0; i < 10; i++) send_beat($urandom, (i == 4));
      @(negedge clk);
      u_if.s_axis_tvalid   = 1'b1;
      u_if.s_axis_tdata    = $urandom;
      u_if.s_axis_tlast    = 1'b1;
      u_if.s00_axi_awaddr  = REG_CONTROL;
      u_if.s00_axi_wdata   = 32'h1;
      u_if.s00_axi_awvalid = 1'b1;
      u_if.s00_axi_wvalid  = 1'b1;
      #1;
      n_cmp++;
      if (!(u_if.s00_axi_awready && u_if.s00_axi_wready && u_if.s_axis_tready)) begin
         n_err++;
         $display("FAIL flush_concurrent: awready=%b wready=%b tready=%b required 111",
                  u_if.s00_axi_awready, u_if.s00_axi_wready, u_if.s_axis_tready);
      end
      @(negedge clk);
      u_if.s_axis_tvalid   = 1'b0;
      u_if.s_axis_tlast    = 1'b0;
      u_if.s00_axi_awvalid = 1'b0;
      u_if.s00_axi_wvalid  = 1'b0;
      u_if.s00_axi_bready  = 1'b1;
      #1;
      n = 0;
      while (!u_if.s00_axi_bvalid && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      n_cmp++;
      if (u_if.s00_axi_bvalid !== 1'b1 || u_if.s00_axi_bresp !== RESP_OKAY) begin
         n_err++;
         $display("FAIL flush_bresp: bvalid=%b bresp=%b required 1/00",
                  u_if.s00_axi_bvalid, u_if.s00_axi_bresp);
      end
      @(negedge clk);
      u_if.s00_axi_bready = 1'b0;
      model_q.delete();
      axi_read(REG_STATUS, d, r);
      n_cmp++;
      if (d !== 32'h0001_0000 || d !== model_status()) begin
         n_err++;
         $display("FAIL flush_status: got %h required 00010000", d);
      end
      axi_read(REG_PKTCNT, d, r);
      n_cmp++;
      if (d !== 32'h0) begin
         n_err++;
         $display("FAIL flush_pktcnt: got %h required 0", d);
      end
      axi_read(REG_DATA, d, r);
      n_cmp++;
      if (d !== 32'h0 || r !== RESP_SLVERR) begin
         n_err++;
         $display("FAIL flush_pop: got %h/%b required 00000000/10", d, r);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      logic [1:0]  r;
      fork
         begin : g_stream
            for (int i = 0; i < 600; i++) send_beat($urandom, ($urandom_range(0, 7) == 0));
            stream_stop();
         end
         begin : g_reader
            logic [31:0] rd;
            logic [1:0]  rr;
            logic [32:0] e;
            int          w;
            int          bad;
            w   = 0;
            bad = 0;
            while (model_q.size() < 8 && w < 200) begin
               @(negedge clk);
               w++;
            end
            for (int i = 0; i < 600; i++) begin
               repeat ($urandom_range(0, 2)) @(negedge clk);
               axi_read(REG_DATA, rd, rr);
               n_cmp++;
               if (model_q.size() == 0) begin
                  n_err++;
                  $display("FAIL b2b_underflow%0d: got %h/%b required no read", i, rd, rr);
               end else begin
                  e = model_q.pop_front();
                  if (rd !== e[31:0] || rr !== RESP_OKAY) begin
                     n_err++;
                     if (bad < 5) $display("FAIL b2b_pop%0d: got %h/%b required %h/00",
                                           i, rd, rr, e[31:0]);
                     bad++;
                  end
               end
               if (i % 40 == 20) begin
                  axi_read(REG_STATUS, rd, rr);
                  n_cmp++;
                  if (rd[15:0] > 16'd512 || rd[17] !== (rd[15:0] == 16'd512) || rd[16] !== 1'b0) begin
                     n_err++;
                     $display("FAIL b2b_level: status=%h required level<=512, full==(level==512)",
                              rd);
                  end
                  axi_write(REG_CONTROL, 32'h2, rr);
                  n_cmp++;
                  if (rr !== RESP_OKAY) begin
                     n_err++;
                     $display("FAIL b2b_bresp: got %b required 00", rr);
                  end
               end
            end
         end
      join
      axi_write(REG_CONTROL, 32'h2, r);
      model_stall = 1'b0;
      axi_read(REG_STATUS, d, r);
      n_cmp++;
      if (d !== model_status() || d !== 32'h0001_0000) begin
         n_err++;
         $display("FAIL b2b_final_status: got %h required %h", d, model_status());
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      logic [1:0]  r;
      int          n;
      for (int i = 0; i < 3; i++) send_beat($urandom, 1'b1);
      stream_stop();
      @(negedge clk);
      u_if.s00_axi_araddr  = REG_DATA;
      u_if.s00_axi_arvalid = 1'b1;
      #1;
      n = 0;
      while (!u_if.s00_axi_arready && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      @(negedge clk);
      u_if.s00_axi_arvalid = 1'b0;
      #1;
      n_cmp++;
      if (u_if.s00_axi_rvalid !== 1'b1) begin
         n_err++;
         $display("FAIL midrst_pending: rvalid=%b required 1", u_if.s00_axi_rvalid);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (u_if.s00_axi_rvalid !== 1'b0 || u_if.s_axis_tready !== 1'b0) begin
         n_err++;
         $display("FAIL midrst_abort: rvalid=%b tready=%b required 0/0",
                  u_if.s00_axi_rvalid, u_if.s_axis_tready);
      end
      model_q.delete();
      model_stall = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      axi_read(REG_STATUS, d, r);
      n_cmp++;
      if (d !== 32'h0001_0000) begin
         n_err++;
         $display("FAIL midrst_status: got %h required 00010000", d);
      end
      axi_read(REG_DATA, d, r);
      n_cmp++;
      if (d !== 32'h0 || r !== RESP_SLVERR) begin
         n_err++;
         $display("FAIL midrst_pop: got %h/%b required 00000000/10", d, r);
      end
   endtask

   initial begin
      test_reset();
      test_packet();
      test_fill_stall();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axis_stream_rxfifo.md
Name: axis_stream_rxfifo

Overview:
- Receive-side counterpart of the AXI-Stream TX FIFO IP.
- Accepts a 32-bit AXI4-Stream slave input into an internal synchronous FIFO.
- Exposes the FIFO to the processor through a 4-register AXI4-Lite slave (S00_AXI): data pop, status, control, packet count.
- Sits in the BD between a stream source (e.g. sensor/serial deframer) and the PS master; software drains it by reading register 0.

Parameters:
- C_S00_AXI_DATA_WIDTH, 32, AXI-Lite data width (only 32 supported).
- C_S00_AXI_ADDR_WIDTH, 4, AXI-Lite address width; 4 word registers.
- FIFO_ADDR_W, 9, log2 FIFO depth (512 entries of {tlast, tdata[31:0]}).

Ports:
- ACLK  in  1  single clock for all logic.
- ARESETN  in  1  asynchronous active-low reset.
- S_AXIS_TDATA  in  32  stream data.
- S_AXIS_TLAST  in  1  end of packet.
- S_AXIS_TVALID  in  1  beat valid.
- S_AXIS_TREADY  out  1  beat accept.
- S00_AXI_AWADDR  in  4  write address.
- S00_AXI_AWPROT  in  3  ignored.
- S00_AXI_AWVALID / S00_AXI_AWREADY  in/out  1  write address handshake.
- S00_AXI_WDATA  in  32  write data.
- S00_AXI_WSTRB  in  4  ignored (full-word writes only).
- S00_AXI_WVALID / S00_AXI_WREADY  in/out  1  write data handshake.
- S00_AXI_BRESP  out  2  write response.
- S00_AXI_BVALID / S00_AXI_BREADY  out/in  1  write response handshake.
- S00_AXI_ARADDR  in  4  read address.
- S00_AXI_ARPROT  in  3  ignored.
- S00_AXI_ARVALID / S00_AXI_ARREADY  in/out  1  read address handshake.
- S00_AXI_RDATA  out  32  read data.
- S00_AXI_RRESP  out  2  read response.
- S00_AXI_RVALID / S00_AXI_RREADY  out/in  1  read data handshake.

Behaviour:
- Reset (ARESETN=0, async): FIFO empty, all pointers, PKT_COUNT and stall flag = 0. All READY/VALID outputs = 0; RDATA = 0; BRESP = RRESP = 0.
- Stream side:
  - S_AXIS_TREADY = !full, registered from the FIFO level.
  - Push on TVALID && TREADY.
  - Stall flag is sticky: set on any cycle with TVALID && !TREADY.
- Write channel FSM, states W_IDLE -> W_RESP:
  - In W_IDLE, once AWVALID && WVALID are both high, AWREADY and WREADY pulse together for 1 cycle and the write takes effect that cycle.
  - BVALID asserts the next cycle with BRESP = OKAY and holds until BREADY, then returns to W_IDLE.
  - No new AW/W is accepted while BVALID is high.
- Read channel FSM, states R_IDLE -> R_DATA:
  - In R_IDLE with ARVALID high, ARREADY pulses for 1 cycle; RDATA/RRESP are registered that cycle.
  - RVALID asserts the next cycle and holds until RREADY.
  - Minimum 2 cycles per read.
- Register map (byte address):
  - 0x0 DATA (RO). Read of a non-empty FIFO returns the head tdata, RRESP = OKAY, and pops it on the AR accept cycle. Read when empty returns 0, RRESP = SLVERR (2'b10), no pop.
  - 0x4 STATUS (RO). [15:0] level (0..512, zero-extended); [16] empty; [17] full; [18] tlast of head entry (0 if empty); [19] stall flag.
  - 0x8 CONTROL (WO, self-clearing, reads 0). bit0 = flush: empty FIFO, PKT_COUNT = 0. bit1 = clear stall flag.
  - 0xC PKT_COUNT (RO). Number of tlast beats currently stored.
- Writes to RO addresses and unused bits are ignored, BRESP = OKAY. Address bits [1:0] are ignored.
- Simultaneous events:
  - Push and pop in the same cycle: level unchanged. Pointers wrap modulo 2^FIFO_ADDR_W; level is FIFO_ADDR_W+1 bits wide.
  - PKT_COUNT: +1 on push with tlast, -1 on pop with tlast; both in the same cycle leaves it unchanged.
  - Flush in the same cycle as a push and/or pop: the read still returns the pre-flush head data, and the flush then wins. Level = 0, PKT_COUNT = 0, the concurrent beat is discarded.
  - Stall set and stall clear in the same cycle: set wins.
- Pop-to-status latency: a STATUS read accepted the cycle after a DATA pop reflects the new level.
- Reset asserted mid-transaction: both FSMs abort to IDLE, the FIFO empties, and no response is issued.

Decomposition:
- Package axis_stream_rxfifo_pkg holds:
  - register offsets (REG_DATA = 0, REG_STATUS = 4, REG_CONTROL = 8, REG_PKTCNT = 12);
  - STATUS bit indices;
  - RESP_OKAY / RESP_SLVERR constants;
  - FSM state enums.
- One sub-module, rxfifo_sync_fifo: parameterised 33-bit-wide synchronous FIFO with push, pop, flush, head data/last, level, full and empty outputs. Async active-low reset on the control state only.

Test Plan:
- Reset, then read 0x4 -> 0x0001_0000 (empty = 1, level = 0); read 0x0 -> RDATA = 0, RRESP = 2'b10.
- Stream 4 beats 0x1..0x4 with TLAST on the 4th; read 0xC -> 1, 0x4 -> 0x0000_0004. Read 0x0 four times -> 1, 2, 3, 4 OKAY; final 0xC -> 0, 0x4 -> 0x0001_0000.
- Stream 513 beats with TVALID held high and no reads:
  - TREADY drops after 512 accepted beats;
  - read 0x4 -> bits 17 and 19 set, level = 512;
  - write 0x8 = 0x2, then read 0x4 -> bit 19 clear.
- Fill 10 beats, write 0x8 = 0x1 while TVALID is held high:
  - the concurrent beat is dropped;
  - read 0x4 -> 0x0001_0000 if TVALID is then low;
  - PKT_COUNT = 0.
- Continuous stream, one beat per cycle, while the master reads DATA back-to-back with random RREADY/BREADY delays -> data order preserved, no loss, level never exceeds 512.
- Assert ARESETN low while RVALID is pending -> RVALID = 0 immediately; after release the FIFO is empty and the next read returns SLVERR.
